fft_output_reorder: RTL

- Downstream consumer of the 64-point in-place FFT control/datapath.
- During the final stage, the FFT emits 32 sample pairs, two bins per cycle, in bit-reversed order.
- This block captures each frame into a ping-pong buffer and streams the bins out one per cycle, in natural order (bin 0..63), with a valid/ready handshake.
- Decouples the fixed 256-cycle FFT frame schedule from a backpressuring sink.

---
 rtl/fft_output_reorder_if.sv | 29 ++
 rtl/fft_output_reorder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder_if.sv
// Stream bundle for fft_output_reorder: bit-reversed sample-pair input, one-sample-per-cycle
// output with valid/ready, and the sticky overflow status. slave = reorder block side.
interface fft_output_reorder_if #(
    parameter int unsigned DW = 16
);
    logic                 in_valid;
    logic                 in_sof;
    logic signed [DW-1:0] in0_re;
    logic signed [DW-1:0] in0_im;
    logic signed [DW-1:0] in1_re;
    logic signed [DW-1:0] in1_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [5:0]           out_idx;
    logic                 out_last;
    logic                 overflow;

    modport master (
        output in_valid, in_sof, in0_re, in0_im, in1_re, in1_im, out_ready,
        input  out_valid, out_re, out_im, out_idx, out_last, overflow
    );

    modport slave (
        input  in_valid, in_sof, in0_re, in0_im, in1_re, in1_im, out_ready,
        output out_valid, out_re, out_im, out_idx, out_last, overflow
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer behind the 64-point FFT: captures bit-reversed pairs, streams bins
// one per cycle. Define BITREV_EN for natural bin order; undefined keeps FFT arrival order.
module fft_output_reorder #(
    parameter int unsigned DW = 16,
    parameter int unsigned N  = 64
) (
    input logic                 clk,
    input logic                 nrst,
    fft_output_reorder_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    logic [2*DW-1:0] mem [2*N];

    logic [4:0]    wcnt;
    logic          wsel;
    logic [1:0]    full;
    logic [1:0]    full_d;
    logic          ovf;
    state_e        state;
    logic          rsel;
    logic [5:0]    rcnt;
    logic          out_valid;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [5:0]    out_idx;
    logic          out_last;

    logic [4:0]      pk;
    logic            accept;
    logic            fill_done;
    logic            hs;
    logic            drain_done;
    logic [5:0]      wa0;
    logic [5:0]      wa1;
    logic [5:0]      raddr;
    logic [5:0]      ridx;
    logic [2*DW-1:0] rdata;

    always_comb begin
        // A start-of-frame pair always restarts the frame at pair 0.
        pk         = bus.in_sof ? 5'd0 : wcnt;
        accept     = bus.in_valid && !full[wsel];
        fill_done  = accept && (pk == 5'd31);
        hs         = (state == StStream) && out_valid && bus.out_ready;
        drain_done = hs && (rcnt == 6'd63);
        full_d     = full;
        if (fill_done) full_d[wsel] = 1'b1;
        if (drain_done) full_d[rsel] = 1'b0;
        // In STREAM the read runs one word ahead so a handshake needs no bubble.
        raddr      = (state == StStream) ? rcnt + 6'd1 : rcnt;
`ifdef BITREV_EN
        wa0  = bitrev6({pk, 1'b0});
        wa1  = bitrev6({pk, 1'b1});
        ridx = raddr;
`else
        wa0  = {pk, 1'b0};
        wa1  = {pk, 1'b1};
        ridx = bitrev6(raddr);
`endif
    end

    assign rdata = mem[{rsel, raddr}];

    always_ff @(posedge clk) begin
        if (nrst && accept) begin
            mem[{wsel, wa0}] <= {bus.in0_re, bus.in0_im};
            mem[{wsel, wa1}] <= {bus.in1_re, bus.in1_im};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wcnt      <= '0;
            wsel      <= 1'b0;
            full      <= '0;
            ovf       <= 1'b0;
            state     <= StIdle;
            rsel      <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            full <= full_d;

            if (bus.in_valid && full[wsel]) begin
                ovf <= 1'b1;
            end else if (accept) begin
                if (fill_done) begin
                    wcnt <= '0;
                    wsel <= ~wsel;
                end else begin
                    wcnt <= pk + 5'd1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (full[rsel]) begin
                        rcnt  <= '0;
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    out_valid        <= 1'b1;
                    {out_re, out_im} <= rdata;
                    out_idx          <= ridx;
                    out_last         <= (raddr == 6'd63);
                    state            <= StStream;
                end
                StStream: begin
                    if (hs) begin
                        if (rcnt == 6'd63) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rsel      <= ~rsel;
                            rcnt      <= '0;
                            state     <= full_d[~rsel] ? StLoad : StIdle;
                        end else begin
                            rcnt             <= rcnt + 6'd1;
                            {out_re, out_im} <= rdata;
                            out_idx          <= ridx;
                            out_last         <= (raddr == 6'd63);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_re    = out_re;
    assign bus.out_im    = out_im;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;
    assign bus.overflow  = ovf;
endmodule
